// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator: stage k moves the operand by 2^k when amount bit k is set.
// Valid/ready flow control with a single global advance enable; the last stage is the output.
module shift_pipe #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_numA,
    input  logic [DATA_WIDTH-1:0] in_numB,
    input  logic [2:0]            in_mode,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic                  out_ovr
);
    localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH);
    localparam int unsigned NumMid      = SHAMT_WIDTH - 1;

    localparam logic [2:0] ModeSll = 3'b000;
    localparam logic [2:0] ModeSrl = 3'b001;
    localparam logic [2:0] ModeSra = 3'b010;
    localparam logic [2:0] ModeRol = 3'b011;
    localparam logic [2:0] ModeRor = 3'b100;

    // Stages 0..SHAMT_WIDTH-2; the final stage is held in the r_out_* registers.
    logic [NumMid-1:0]      r_valid;
    logic [NumMid-1:0]      r_ovr;
    logic [DATA_WIDTH-1:0]  r_data [NumMid];
    logic [2:0]             r_mode [NumMid];
    // Remaining amount, pre-shifted so bit 0 always controls the next stage.
    logic [SHAMT_WIDTH-1:0] r_amt  [NumMid];

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_result;
    logic                  r_out_zero;
    logic                  r_out_ovr;

    logic                  w_adv;
    logic                  w_ovr_in;
    logic [DATA_WIDTH-1:0] w_step [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0] w_final;

    function automatic logic [DATA_WIDTH-1:0] f_step(
        input logic [DATA_WIDTH-1:0] d,
        input logic [2:0]            m,
        input int unsigned           n
    );
        case (m)
            ModeSll: return d << n;
            ModeSrl: return d >> n;
            ModeSra: return $unsigned($signed(d) >>> n);
            ModeRol: return (d << n) | (d >> (DATA_WIDTH - n));
            ModeRor: return (d >> n) | (d << (DATA_WIDTH - n));
            default: return d;
        endcase
    endfunction

    assign w_adv     = !r_out_valid || in_ready;
    assign out_ready = w_adv;
    // Reserved modes never report an overrange amount.
    assign w_ovr_in  = (|in_numB[DATA_WIDTH-1:SHAMT_WIDTH]) && (in_mode <= ModeRor);

    always_comb begin
        w_step[0] = in_numB[0] ? f_step(in_numA, in_mode, 1) : in_numA;
        for (int k = 1; k < SHAMT_WIDTH; k++) begin
            w_step[k] = r_amt[k-1][0] ? f_step(r_data[k-1], r_mode[k-1], 32'(1) << k)
                                      : r_data[k-1];
        end
        // Overrange: logical shifts flush to zero, SRA to the sign (MSB survives >>>).
        w_final = w_step[SHAMT_WIDTH-1];
        if (r_ovr[NumMid-1]) begin
            case (r_mode[NumMid-1])
                ModeSll, ModeSrl: w_final = '0;
                ModeSra:          w_final = {DATA_WIDTH{w_step[SHAMT_WIDTH-1][DATA_WIDTH-1]}};
                default:          w_final = w_step[SHAMT_WIDTH-1];
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_valid      <= '0;
            r_ovr        <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_ovr    <= 1'b0;
            for (int k = 0; k < NumMid; k++) begin
                r_data[k] <= '0;
                r_mode[k] <= '0;
                r_amt[k]  <= '0;
            end
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            r_ovr[0]   <= w_ovr_in;
            r_data[0]  <= w_step[0];
            r_mode[0]  <= in_mode;
            r_amt[0]   <= in_numB[SHAMT_WIDTH-1:0] >> 1;
            for (int k = 1; k < NumMid; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_ovr[k]   <= r_ovr[k-1];
                r_data[k]  <= w_step[k];
                r_mode[k]  <= r_mode[k-1];
                r_amt[k]   <= r_amt[k-1] >> 1;
            end
            r_out_valid  <= r_valid[NumMid-1];
            r_out_result <= w_final;
            r_out_zero   <= (w_final == '0);
            r_out_ovr    <= r_ovr[NumMid-1];
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_ovr    = r_out_ovr;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe (64-bit, 6 stages): directed vectors plus a scoreboarded random sweep.
module tb_shift_pipe;
    logic        in_clk;
    logic        in_rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_numA;
    logic [63:0] in_numB;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        in_ready;
    logic [63:0] out_result;
    logic        out_zero;
    logic        out_ovr;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int n_stall = 0;
    int cyc     = 0;
    int rdy_mode = 0;
    int bp_start = 0;

    logic [64:0] sb [$];
    logic        stall_prev = 1'b0;
    logic [63:0] prev_res;
    logic        prev_zero;
    logic        prev_ovr;

    shift_pipe #(.DATA_WIDTH(64)) dut (
        .in_clk     (in_clk),
        .in_rst_n   (in_rst_n),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .in_numA    (in_numA),
        .in_numB    (in_numB),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovr    (out_ovr)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Returns {ovr, result}.
    function automatic logic [64:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [2:0] m);
        logic [63:0] r;
        logic        ovr;
        int unsigned n;
        n   = int'(b[5:0]);
        ovr = (b[63:6] != 58'd0);
        case (m)
            3'd0: r = ovr ? 64'd0 : a << n;
            3'd1: r = ovr ? 64'd0 : a >> n;
            3'd2: r = ovr ? {64{a[63]}} : 64'($signed(a) >>> n);
            3'd3: r = (a << n) | (a >> (64 - n));
            3'd4: r = (a >> n) | (a << (64 - n));
            default: begin
                r   = a;
                ovr = 1'b0;
            end
        endcase
        return {ovr, r};
    endfunction

    initial begin
        in_ready = 1'b1;
        forever begin
            @(posedge in_clk);
            #1;
            case (rdy_mode)
                1:       in_ready = 1'($urandom_range(0, 1));
                2:       in_ready = !((cyc - bp_start) >= 7 && (cyc - bp_start) <= 12);
                default: in_ready = 1'b1;
            endcase
        end
    end

    // Monitor: samples on the falling edge, mid-cycle between input changes and the active edge.
    always @(negedge in_clk) begin
        logic [64:0] e;
        if (!in_rst_n) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_valid", 64'(out_valid), 64'd1);
                check_eq("hold_result", out_result, prev_res);
                check_eq("hold_zero", 64'(out_zero), 64'(prev_zero));
                check_eq("hold_ovr", 64'(out_ovr), 64'(prev_ovr));
            end
            if (out_valid && !in_ready) begin
                check_eq("stall_ready", 64'(out_ready), 64'd0);
                stall_prev = 1'b1;
                prev_res   = out_result;
                prev_zero  = out_zero;
                prev_ovr   = out_ovr;
                n_stall++;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && in_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check_eq("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("sb_result", out_result, e[63:0]);
                    check_eq("sb_ovr", 64'(out_ovr), 64'(e[64]));
                    check_eq("sb_zero", 64'(out_zero), 64'(e[63:0] == 64'd0));
                end
            end
            if (in_valid && out_ready) sb.push_back(ref_model(in_numA, in_numB, in_mode));
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] m);
        int   guard;
        logic acc;
        guard    = 0;
        in_valid = 1'b1;
        in_numA  = a;
        in_numB  = b;
        in_mode  = m;
        do begin
            @(negedge in_clk);
            acc = out_ready;
            @(posedge in_clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) check_eq("send_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 1000) begin
            @(posedge in_clk);
            #1;
            guard++;
        end
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // One beat into an idle pipe with in_ready high; output must appear exactly 6 edges later.
    task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] m, input logic [63:0] exp_res,
                            input logic exp_zero, input logic exp_ovr);
        send(a, b, m);
        repeat (4) begin
            @(posedge in_clk);
            #1;
        end
        check_eq({tag, "_early"}, 64'(out_valid), 64'd0);
        @(posedge in_clk);
        #1;
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_result"}, out_result, exp_res);
        check_eq({tag, "_zero"}, 64'(out_zero), 64'(exp_zero));
        check_eq({tag, "_ovr"}, 64'(out_ovr), 64'(exp_ovr));
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        int          base;
        int          stale;
        logic [63:0] ra;
        logic [63:0] rb;
        in_rst_n = 1'b0;
        in_valid = 1'b0;
        in_numA  = '0;
        in_numB  = '0;
        in_mode  = '0;
        #2;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_ready", 64'(out_ready), 64'd1);
        check_eq("rst_result", out_result, 64'd0);
        check_eq("rst_zero", 64'(out_zero), 64'd0);
        check_eq("rst_ovr", 64'(out_ovr), 64'd0);
        repeat (3) @(posedge in_clk);
        #1;
        in_rst_n = 1'b1;
        @(posedge in_clk);
        #1;

        directed("sra4", 64'h8000_0000_0000_0000, 64'd4, 3'b010, 64'hF800_0000_0000_0000, 0, 0);
        directed("ror65", 64'h1, 64'd65, 3'b100, 64'h8000_0000_0000_0000, 0, 1);
        directed("sll64", 64'hFF, 64'd64, 3'b000, 64'h0, 1, 1);
        directed("srl4", 64'hF0, 64'd4, 3'b001, 64'h0F, 0, 0);
        directed("rol1", 64'h8000_0000_0000_0001, 64'd1, 3'b011, 64'h3, 0, 0);
        directed("rsv5", 64'h1234, 64'd8, 3'b101, 64'h1234, 0, 0);
        directed("rsv7big", 64'hABCD, 64'd100, 3'b111, 64'hABCD, 0, 0);
        directed("sra0", 64'h8000_0000_0000_0000, 64'd0, 3'b010, 64'h8000_0000_0000_0000, 0, 0);
        directed("sra200", 64'h8000_0000_0000_0000, 64'd200, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        directed("rol127", 64'h1, 64'd127, 3'b011, 64'h8000_0000_0000_0000, 0, 1);
        directed("srl63", 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 3'b001, 64'h1, 0, 0);

        // Backpressure: in_ready low for relative cycles 7..12 while 8 beats stream in.
        rdy_mode = 2;
        bp_start = cyc;
        base     = n_out;
        for (int i = 0; i < 8; i++) send(64'h1, 64'(i), 3'b000);
        drain();
        check_eq("bp_count", 64'(n_out - base), 64'd8);
        check_eq("bp_stalled", 64'(n_stall >= 5), 64'd1);
        rdy_mode = 0;
        repeat (2) @(posedge in_clk);
        #1;

        // Reset with three beats in flight, the oldest already presented.
        send(64'h11, 64'd1, 3'b000);
        send(64'h22, 64'd2, 3'b000);
        send(64'h33, 64'd3, 3'b000);
        repeat (3) begin
            @(posedge in_clk);
            #1;
        end
        check_eq("rif_pre_valid", 64'(out_valid), 64'd1);
        in_rst_n = 1'b0;
        #1;
        check_eq("rif_valid", 64'(out_valid), 64'd0);
        check_eq("rif_result", out_result, 64'd0);
        check_eq("rif_zero", 64'(out_zero), 64'd0);
        check_eq("rif_ovr", 64'(out_ovr), 64'd0);
        check_eq("rif_ready", 64'(out_ready), 64'd1);
        @(posedge in_clk);
        #1;
        in_rst_n = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge in_clk);
            if (out_valid) stale++;
        end
        check_eq("rif_stale", 64'(stale), 64'd0);
        @(posedge in_clk);
        #1;
        directed("post_rst", 64'h0F, 64'd4, 3'b000, 64'hF0, 0, 0);

        // Random sweep with random backpressure and idle gaps.
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = 64'd0;
                1:       rb = 64'($urandom_range(0, 63));
                2:       rb = {$urandom, $urandom};
                default: rb = 64'(64 + $urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(posedge in_clk);
                #1;
            end
            send(ra, rb, 3'($urandom_range(0, 7)));
        end
        drain();
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter DATA_WIDTH, 64, operand and result width in bits; SHALL be a power of two, at least 8.
REQ-002 Derived constant SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount bits and pipeline depth; SHALL NOT be overridable.
REQ-003 in_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 in_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat presented.
REQ-006 out_ready  output  1  block accepts a beat this cycle.
REQ-007 in_numA  input  DATA_WIDTH  value to shift.
REQ-008 in_numB  input  DATA_WIDTH  shift amount, unsigned.
REQ-009 in_mode  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
REQ-010 out_valid  output  1  result beat presented.
REQ-011 in_ready  input  1  downstream accepts the result.
REQ-012 out_result  output  DATA_WIDTH  shifted value.
REQ-013 out_zero  output  1  out_result equals zero.
REQ-014 out_ovr  output  1  in_numB of this beat was at least DATA_WIDTH.

Function
REQ-015 The datapath SHALL be SHAMT_WIDTH registered stages; stage k SHALL shift or rotate by 2^k when bit k of the amount is 1, otherwise pass the value through.
REQ-016 Each stage SHALL carry a valid bit, its data, the mode, the remaining amount bits and an ovr flag.
REQ-017 Pipeline advance enable: adv = !out_valid || in_ready; every stage SHALL load from its predecessor only when adv=1, otherwise hold.
REQ-018 out_ready SHALL equal adv; a beat SHALL be accepted when in_valid && out_ready.
REQ-019 A stage SHALL load valid=0 when adv=1 and its predecessor is invalid; bubbles SHALL NOT stall the pipe.
REQ-020 Latency SHALL be exactly SHAMT_WIDTH cycles from acceptance to out_valid when in_ready is held high; throughput SHALL be one beat per cycle.
REQ-021 out_result, out_zero and out_ovr SHALL be held stable while out_valid && !in_ready.
REQ-022 Ordering SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-023 SLL/SRL SHALL zero-fill; SRA SHALL fill with in_numA[DATA_WIDTH-1]; ROL/ROR SHALL rotate with no bit lost.
REQ-024 ovr is set when in_numB[DATA_WIDTH-1:SHAMT_WIDTH] is nonzero.
REQ-025 With ovr set: SLL and SRL results SHALL be 0, SRA SHALL be all copies of the sign bit, and ROL/ROR SHALL use in_numB mod DATA_WIDTH.
REQ-026 Reserved modes SHALL return in_numA unchanged with out_ovr=0.
REQ-027 An amount of 0 SHALL return in_numA unchanged in every mode.
REQ-028 out_zero SHALL be a registered copy derived from the final-stage result, valid with out_valid.

Reset
REQ-029 While in_rst_n=0, all stage valid bits, out_valid, out_result, out_zero and out_ovr SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 out_ready SHALL read 1 during reset because out_valid=0.
REQ-031 A reset asserted mid-operation SHALL discard all in-flight beats, with no partial output after release.
REQ-032 The first beat accepted after in_rst_n rises SHALL complete normally with latency SHAMT_WIDTH.

Verification (DATA_WIDTH=64, latency 6)
REQ-033 The bench SHALL check SRA: in_numA=0x8000_0000_0000_0000, in_numB=4, in_mode=010, in_ready=1 -> 6 cycles later out_valid=1 and out_result=0xF800_0000_0000_0000.
REQ-034 The bench SHALL check ROR with overrange amount: in_numA=0x1, in_numB=65, in_mode=100 -> out_result=0x8000_0000_0000_0000, out_ovr=1.
REQ-035 The bench SHALL check SLL with overrange amount: in_numA=0xFF, in_numB=64, in_mode=000 -> out_result=0, out_zero=1, out_ovr=1.
REQ-036 The bench SHALL check backpressure: 8 back-to-back beats with in_ready low from cycle 7 to cycle 12 -> out_ready=0 while stalled, output held stable, all 8 results in order with no loss.
REQ-037 The bench SHALL check reset in flight: 3 beats in flight, then in_rst_n=0 for 1 cycle -> out_valid=0 at once and no stale results ever appear.
REQ-038 The bench SHALL check random sweep: random in_numA, in_numB and in_mode, including reserved modes and in_numB=0, with random in_ready -> match a reference model on every beat.
